// File: rtl/sd_spi_cmd.sv
// -----------------------------------------------------------------------------
// sd_spi_cmd
//   SPI-mode SD card command engine. It latches one 6-byte command frame
//   (command byte, 32-bit argument, CRC byte) and shifts it out MSB-first on D1.
//   It then polls D0 for the R1 response. For CMD8 and CMD58 it also reads the
//   32-bit R7/R3 payload. Eight trailing clocks (Nec) follow, and the result is
//   held with a level `done`. The block generates sd_clk itself (SPI mode 0,
//   idle low). Chip select belongs to the caller.
//
// Parameters
//   CLK_DIV  clk cycles per sd_clk half-period (>=1); one bit = 2*CLK_DIV clk
//   NCR_MAX  response-wait limit in bytes (NCR_MAX*8 bit times)
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   start               level request, sampled only in IDLE
//   cmd_number/args/crc command frame fields, sent exactly as given
//   done                high in DONE until start falls
//   timeout             valid with done: no R1 start bit was seen
//   response_flags      R1 byte (0xFF on timeout)
//   data_transmission   R7/R3 payload (0 if none)
//   sd_clk, D1, D0      SPI clock, MOSI, MISO
//   dbg_state           current FSM state (encoding of state_t below)
//
// Handshake: start/done are a level request/acknowledge pair. start is sampled
//   only in IDLE, and a high sample latches the frame. done rises once the
//   transaction is complete and stays high while start stays high. Dropping
//   start returns the block to IDLE on the next cycle. A new command therefore
//   needs start low for at least one cycle after done.
// -----------------------------------------------------------------------------
module sd_spi_cmd #(
  parameter int CLK_DIV = 2,
  parameter int NCR_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  cmd_number,
  input  logic [31:0] cmd_args,
  input  logic [7:0]  cmd_crc,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  response_flags,
  output logic [31:0] data_transmission,
  output logic        sd_clk,
  output logic        D1,
  input  logic        D0,
  output logic [2:0]  dbg_state
);

  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_BITS = NCR_MAX * 8;
  localparam int WAIT_W    = $clog2(WAIT_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_R1   = 3'd2,
    S_READ_R1   = 3'd3,
    S_READ_TAIL = 3'd4,
    S_TRAIL     = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t state, next_state;

  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [47:0]       frame_sr;
  logic              is_long;
  logic              d0_q;

  logic active, tick, rise, bit_end;
  logic last_send, last_r1, last_tail, last_trail, wait_expired;

  // FSM strobes
  logic load_frame, shift_frame, end_frame, cap_r1, cap_data;
  logic set_timeout, count_wait;

  assign dbg_state = state;

  // The bit clock runs only in the states that move bits on the wire.
  assign active  = (state == S_SEND) || (state == S_WAIT_R1) || (state == S_READ_R1) ||
                   (state == S_READ_TAIL) || (state == S_TRAIL);
  assign tick    = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise    = tick && !sd_clk;   // mid-bit: sample D0
  assign bit_end = tick && sd_clk;    // bit boundary: advance D1 / state

  assign last_send    = (bit_cnt == 6'd47);
  // The R1 start bit is consumed in WAIT_R1, so READ_R1 carries 7 bits.
  assign last_r1      = (bit_cnt == 6'd6);
  assign last_tail    = (bit_cnt == 6'd31);
  assign last_trail   = (bit_cnt == 6'd7);
  assign wait_expired = (wait_cnt == WAIT_W'(WAIT_BITS - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = S_SEND;
      S_SEND:      if (bit_end && last_send) next_state = S_WAIT_R1;
      S_WAIT_R1: begin
        if (bit_end) begin
          // A zero in the final allowed bit is still a valid start bit.
          if (!d0_q)             next_state = S_READ_R1;
          else if (wait_expired) next_state = S_TRAIL;
        end
      end
      S_READ_R1:   if (bit_end && last_r1) next_state = is_long ? S_READ_TAIL : S_TRAIL;
      S_READ_TAIL: if (bit_end && last_tail) next_state = S_TRAIL;
      S_TRAIL:     if (bit_end && last_trail) next_state = S_DONE;
      S_DONE:      if (!start) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    load_frame  = 1'b0;
    shift_frame = 1'b0;
    end_frame   = 1'b0;
    cap_r1      = 1'b0;
    cap_data    = 1'b0;
    set_timeout = 1'b0;
    count_wait  = 1'b0;
    case (state)
      S_IDLE:      load_frame = start;
      S_SEND: begin
        shift_frame = bit_end && !last_send;
        end_frame   = bit_end && last_send;
      end
      S_WAIT_R1: begin
        cap_r1      = rise && !D0;
        set_timeout = bit_end && d0_q && wait_expired;
        count_wait  = bit_end && d0_q && !wait_expired;
      end
      S_READ_R1:   cap_r1   = rise;
      S_READ_TAIL: cap_data = rise;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt           <= '0;
      sd_clk            <= 1'b0;
      D1                <= 1'b1;
      frame_sr          <= '0;
      is_long           <= 1'b0;
      d0_q              <= 1'b1;
      response_flags    <= 8'hFF;
      data_transmission <= '0;
      timeout           <= 1'b0;
      wait_cnt          <= '0;
      bit_cnt           <= '0;
      done              <= 1'b0;
    end else begin
      // Divider and SPI clock. Both are forced idle whenever no bits are moving.
      if (!active) begin
        div_cnt <= '0;
        sd_clk  <= 1'b0;
      end else if (tick) begin
        div_cnt <= '0;
        sd_clk  <= ~sd_clk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // MOSI changes only at load or at a bit boundary, where sd_clk is low.
      if (load_frame)       D1 <= cmd_number[7];
      else if (shift_frame) D1 <= frame_sr[46];
      else if (end_frame)   D1 <= 1'b1;
      else if (state != S_SEND) D1 <= 1'b1;

      if (load_frame) begin
        frame_sr <= {cmd_number, cmd_args, cmd_crc};
        is_long  <= (cmd_number == 8'h48) || (cmd_number == 8'h7A);
      end else if (shift_frame) begin
        frame_sr <= {frame_sr[46:0], 1'b0};
      end

      if (rise) d0_q <= D0;

      if (load_frame)  response_flags <= 8'hFF;
      else if (cap_r1) response_flags <= {response_flags[6:0], D0};

      if (load_frame)    data_transmission <= '0;
      else if (cap_data) data_transmission <= {data_transmission[30:0], D0};

      if (load_frame)       timeout <= 1'b0;
      else if (set_timeout) timeout <= 1'b1;

      if (load_frame)      wait_cnt <= '0;
      else if (count_wait) wait_cnt <= wait_cnt + WAIT_W'(1);

      // The wait phase is counted by wait_cnt, so bit_cnt never exceeds 47.
      if (next_state != state)                 bit_cnt <= '0;
      else if (bit_end && state != S_WAIT_R1) bit_cnt <= bit_cnt + 6'd1;

      done <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd.sv
module tb_sd_spi_cmd;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  cmd_number;
  logic [31:0] cmd_args;
  logic [7:0]  cmd_crc;
  logic        done;
  logic        timeout;
  logic [7:0]  response_flags;
  logic [31:0] data_transmission;
  logic        sd_clk;
  logic        D1;
  logic        D0 = 1'b1;
  logic [2:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  sd_spi_cmd #(.CLK_DIV(2), .NCR_MAX(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .cmd_number        (cmd_number),
    .cmd_args          (cmd_args),
    .cmd_crc           (cmd_crc),
    .done              (done),
    .timeout           (timeout),
    .response_flags    (response_flags),
    .data_transmission (data_transmission),
    .sd_clk            (sd_clk),
    .D1                (D1),
    .D0                (D0),
    .dbg_state         (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- card model
  // Captures the first 48 MOSI bits on sd_clk rising edges. After the frame it
  // presents response bits on falling edges: resp_ones 1s first, then the
  // bytes in resp_bytes MSB first, then 1s again.
  logic        card_rst = 1'b0;
  logic [7:0]  resp_bytes [8];
  int          resp_nbytes = 0;
  int          resp_ones   = 0;
  int          rise_cnt    = 0;
  int          total_rises = 0;
  int          resp_idx    = 0;
  logic [47:0] mosi_frame  = '0;

  function automatic logic resp_bit(input int k);
    int j;
    logic [7:0] b;
    if (k < resp_ones) return 1'b1;
    j = k - resp_ones;
    if (j / 8 < resp_nbytes) begin
      b = resp_bytes[j / 8];
      return b[7 - (j % 8)];
    end
    return 1'b1;
  endfunction

  always @(posedge sd_clk or negedge sd_clk or posedge card_rst) begin
    if (card_rst) begin
      rise_cnt   <= 0;
      resp_idx   <= 0;
      mosi_frame <= '0;
      D0         <= 1'b1;
    end else if (sd_clk === 1'b1) begin
      total_rises <= total_rises + 1;
      if (rise_cnt < 48) mosi_frame <= {mosi_frame[46:0], D1};
      rise_cnt <= rise_cnt + 1;
    end else if (rise_cnt >= 48) begin
      D0       <= resp_bit(resp_idx);
      resp_idx <= resp_idx + 1;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic card_load(input int ones, input int nb, input logic [63:0] bytes);
    resp_ones   = ones;
    resp_nbytes = nb;
    for (int i = 0; i < 8; i++) resp_bytes[i] = 8'hFF;
    for (int i = 0; i < nb; i++) resp_bytes[i] = bytes[8*(nb-1-i) +: 8];
    card_rst = 1'b1;
    #1;
    card_rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] n, input logic [31:0] a, input logic [7:0] c);
    cmd_number = n;
    cmd_args   = a;
    cmd_crc    = c;
    start      = 1'b1;
  endtask

  // Inputs must be ignored once latched, so they are scrambled after the latch edge.
  task automatic scramble_inputs();
    cmd_number = 8'($urandom_range(0, 255));
    cmd_args   = $urandom;
    cmd_crc    = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max_cyc) begin
      step(1);
      cyc++;
      if (cyc == 1) scramble_inputs();
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  // ---------------------------------------------------------------- scoreboard
  // Expected MOSI frames, popped as each transaction completes.
  logic [47:0] exp_q[$];
  logic [47:0] exp_frame;

  task automatic check_frame(input string tag);
    exp_frame = exp_q.pop_front();
    chk(tag, 64'(mosi_frame), 64'(exp_frame));
  endtask

  // ---------------------------------------------------------------- stimulus
  int lat;
  int r0;
  int n;

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    cmd_number = '0;
    cmd_args   = '0;
    cmd_crc    = '0;
    card_load(0, 0, 64'd0);
    step(3);

    // Reset values
    chk("rst_done",    64'(done), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_flags",   64'(response_flags), 64'hFF);
    chk("rst_data",    64'(data_transmission), 64'd0);
    chk("rst_sd_clk",  64'(sd_clk), 64'd0);
    chk("rst_d1",      64'(D1), 64'd1);
    chk("rst_state",   64'(dbg_state), 64'd0);
    reset_n = 1'b1;
    step(2);
    chk("idle_state", 64'(dbg_state), 64'd0);

    // CMD0: R1 = 0x01 after two 0xFF bytes; latency (48+16+8+8)*4+2 = 322
    card_load(16, 1, 64'h01);
    exp_q.push_back(48'h40_00000000_95);
    send_cmd(8'h40, 32'h0, 8'h95);
    wait_done(2000, lat);
    chk("cmd0_latency", 64'(lat), 64'd322);
    check_frame("cmd0_frame");
    chk("cmd0_flags",   64'(response_flags), 64'h01);
    chk("cmd0_timeout", 64'(timeout), 64'd0);
    chk("cmd0_data",    64'(data_transmission), 64'd0);
    chk("cmd0_sd_clk",  64'(sd_clk), 64'd0);
    chk("cmd0_d1",      64'(D1), 64'd1);
    chk("cmd0_state",   64'(dbg_state), 64'd6);
    start = 1'b0;
    step(1);
    chk("cmd0_to_idle", 64'(dbg_state), 64'd0);
    step(1);
    chk("cmd0_done_low", 64'(done), 64'd0);

    // CMD8: one 0xFF, R1 0x01, payload 0x000001AA; (48+8+8+32+8)*4+2 = 418
    card_load(8, 5, 64'h01_00_00_01_AA);
    exp_q.push_back(48'h48_000001AA_87);
    send_cmd(8'h48, 32'h1AA, 8'h87);
    wait_done(3000, lat);
    chk("cmd8_latency", 64'(lat), 64'd418);
    check_frame("cmd8_frame");
    chk("cmd8_flags",   64'(response_flags), 64'h01);
    chk("cmd8_data",    64'(data_transmission), 64'h000001AA);
    chk("cmd8_timeout", 64'(timeout), 64'd0);
    start = 1'b0;
    step(2);

    // CMD55 with D0 stuck high: timeout after 64 wait bits; (48+64+8)*4+2 = 482
    card_load(0, 0, 64'd0);
    exp_q.push_back(48'h77_00000000_65);
    send_cmd(8'h77, 32'h0, 8'h65);
    wait_done(3000, lat);
    chk("cmd55_latency", 64'(lat), 64'd482);
    check_frame("cmd55_frame");
    chk("cmd55_timeout", 64'(timeout), 64'd1);
    chk("cmd55_flags",   64'(response_flags), 64'hFF);
    chk("cmd55_data",    64'(data_transmission), 64'd0);
    chk("cmd55_sd_clk",  64'(sd_clk), 64'd0);

    // start held high through DONE: no second frame
    r0 = total_rises;
    step(40);
    chk("hold_done",   64'(done), 64'd1);
    chk("hold_state",  64'(dbg_state), 64'd6);
    chk("hold_no_clk", 64'(total_rises), 64'(r0));

    // Drop start for one cycle, then CMD16 with the start bit in wait bit 63
    start = 1'b0;
    step(1);
    card_load(63, 1, 64'h00);
    exp_q.push_back(48'h50_00000200_15);
    send_cmd(8'h50, 32'h200, 8'h15);
    step(1);
    scramble_inputs();
    chk("cmd16_timeout_clr", 64'(timeout), 64'd0);
    chk("cmd16_flags_clr",   64'(response_flags), 64'hFF);
    chk("cmd16_done_clr",    64'(done), 64'd0);
    chk("cmd16_state_send",  64'(dbg_state), 64'd1);
    wait_done(3000, lat);
    chk("cmd16_latency", 64'(lat + 1), 64'd510);
    check_frame("cmd16_frame");
    chk("cmd16_flags",   64'(response_flags), 64'h00);
    chk("cmd16_timeout", 64'(timeout), 64'd0);
    start = 1'b0;
    step(2);

    // Reset pulsed in the middle of SEND (sd_clk high in bit 20)
    card_load(16, 1, 64'h01);
    send_cmd(8'h40, 32'h0, 8'h95);
    n = 0;
    while (rise_cnt < 20 && n < 1000) begin
      step(1);
      n++;
    end
    chk("rst_mid_reached", 64'(rise_cnt), 64'd20);
    chk("rst_mid_clk_hi",  64'(sd_clk), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_sd_clk", 64'(sd_clk), 64'd0);
    chk("rst_mid_d1",     64'(D1), 64'd1);
    chk("rst_mid_done",   64'(done), 64'd0);
    chk("rst_mid_flags",  64'(response_flags), 64'hFF);
    chk("rst_mid_state",  64'(dbg_state), 64'd0);
    step(1);
    chk("rst_edge_sd_clk", 64'(sd_clk), 64'd0);
    chk("rst_edge_d1",     64'(D1), 64'd1);
    start   = 1'b0;
    reset_n = 1'b1;
    step(2);
    card_load(16, 1, 64'h01);
    exp_q.push_back(48'h40_00000000_95);
    send_cmd(8'h40, 32'h0, 8'h95);
    wait_done(2000, lat);
    chk("post_rst_latency", 64'(lat), 64'd322);
    check_frame("post_rst_frame");
    chk("post_rst_flags",   64'(response_flags), 64'h01);
    chk("post_rst_timeout", 64'(timeout), 64'd0);
    start = 1'b0;
    step(2);

    // ---------------------------------------------------------------- report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
